muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit that owns the architectural HI/LO registers.
- Accepts the MULT/MULTU/DIV/DIVU operations, using the same 5-bit ALUControl codes as the single-cycle ALU. Those codes produce no usable HI/LO in the ALU.
- Sits beside the ALU in EX. busy_o stalls the pipeline; hi_o/lo_o feed MFHI/MFLO; MTHI/MTLO write through dedicated ports.

---
 rtl/muldiv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Optional MULDIV_EARLY_OUT_EN: multiply RUN stops after the last set multiplier bit.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [4:0]       alu_control_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_out_q, dbz_out_d;
`ifdef MULDIV_EARLY_OUT_EN
  logic [CW-1:0]      shamt_q, shamt_d;
  logic [CW-1:0]      mul_len;
`endif

  logic               is_mul_op, is_div_op, is_signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_mul_op    = (alu_control_i == OP_MULT) || (alu_control_i == OP_MULTU);
    is_div_op    = (alu_control_i == OP_DIV)  || (alu_control_i == OP_DIVU);
    is_signed_op = (alu_control_i == OP_MULT) || (alu_control_i == OP_DIV);
    a_mag = (is_signed_op && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    b_mag = (is_signed_op && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Iterations needed = index of the top set multiplier bit + 1, at least one.
  always_comb begin
    mul_len = CW'(1);
    for (int i = 0; i < WIDTH; i++) begin
      if (b_mag[i]) mul_len = CW'(i + 1);
    end
  end
`endif

  // Multiply keeps the multiplier in acc low half and shifts right;
  // divide keeps remainder:quotient in acc and shifts left.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
`ifdef MULDIV_EARLY_OUT_EN
    mul_prod  = acc_q >> shamt_q;
`else
    mul_prod  = acc_q;
`endif
    prod_fix  = neg_q ? -mul_prod : mul_prod;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    shamt_d   = shamt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i && (is_mul_op || is_div_op)) begin
          a_d       = a_mag;
          b_d       = b_mag;
          is_div_d  = is_div_op;
          neg_d     = is_signed_op & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
          neg_rem_d = is_signed_op & src_a_i[WIDTH-1];
          dbz_d     = is_div_op && (src_b_i == '0);
          cnt_d     = CW'(WIDTH);
          busy_d    = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
          shamt_d   = '0;
`endif
          if (is_div_op && (src_b_i == '0)) begin
            // Raw dividend is kept so HI can return it untouched.
            acc_d   = {{WIDTH{1'b0}}, src_a_i};
            state_d = S_FIX;
          end else if (is_div_op) begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            state_d = S_RUN;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            state_d = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
            cnt_d   = mul_len;
            shamt_d = CW'(WIDTH) - mul_len;
`endif
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dbz_q) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d    = 1'b0;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        cnt_d     = '0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      shamt_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
`ifdef MULDIV_EARLY_OUT_EN
      shamt_q   <= shamt_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_out_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_muldiv_unit;

  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  alu_control_i = 5'b0;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        hi_we_i = 1'b0;
  logic        lo_we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .alu_control_i(alu_control_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Issues one op; lat = index n of edge En after which done_o was first seen (0 on timeout).
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int pulse, output logic busy1, output logic dbz);
    @(negedge clk);
    start_i = 1'b1; alu_control_i = op; src_a_i = a; src_b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    busy1 = busy_o; lat = 0; pulse = 0; dbz = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done_o) begin lat = n; dbz = div_by_zero_o; break; end
    end
    while (done_o && pulse < 4) begin pulse++; @(negedge clk); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({busy_o, done_o, div_by_zero_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy_o, done_o, div_by_zero_o}); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", hi_o); end
    total++; if (lo_o !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", lo_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int lat, pulse; logic busy1, dbz;
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, pulse, busy1, dbz);
    total++; if (hi_o !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_max_hi got=%h exp=fffffffe", hi_o); end
    total++; if (lo_o !== 32'h00000001) begin bad++; $display("FAIL multu_max_lo got=%h exp=00000001", lo_o); end
    total++; if (lat !== 33) begin bad++; $display("FAIL multu_max_latency got=%0d exp=33", lat); end
    total++; if (pulse !== 1) begin bad++; $display("FAIL multu_done_width got=%0d exp=1", pulse); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL multu_busy got=%b exp=1", busy1); end
    do_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, pulse, busy1, dbz);
    total++; if (hi_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi_o); end
    total++; if (lo_o !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo_o); end
    do_op(OP_MULTU, 32'd3, 32'd5, lat, pulse, busy1, dbz);
    total++; if (lo_o !== 32'd15) begin bad++; $display("FAIL multu_small_lo got=%h exp=0000000f", lo_o); end
    total++; if (hi_o !== 32'd0) begin bad++; $display("FAIL multu_small_hi got=%h exp=00000000", hi_o); end
`ifdef MULDIV_EARLY_OUT_EN
    total++; if (lat !== 4) begin bad++; $display("FAIL multu_small_latency got=%0d exp=4", lat); end
`else
    total++; if (lat !== 33) begin bad++; $display("FAIL multu_small_latency got=%0d exp=33", lat); end
`endif
  endtask

  task automatic test_div();
    int lat, pulse; logic busy1, dbz;
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, pulse, busy1, dbz);
    total++; if (lo_o !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo got=%h exp=fffffffd", lo_o); end
    total++; if (hi_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hi_o); end
    total++; if (lat !== 33) begin bad++; $display("FAIL div_latency got=%0d exp=33", lat); end
    do_op(OP_DIVU, 32'd7, 32'd2, lat, pulse, busy1, dbz);
    total++; if (lo_o !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h exp=00000003", lo_o); end
    total++; if (hi_o !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h exp=00000001", hi_o); end
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, pulse, busy1, dbz);
    total++; if (lo_o !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo_o); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi_o); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div_ovf_flag got=%b exp=0", dbz); end
  endtask

  task automatic test_div_by_zero();
    int lat, pulse; logic busy1, dbz;
    do_op(OP_DIVU, 32'h1234, 32'h0, lat, pulse, busy1, dbz);
    total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    total++; if (pulse !== 1) begin bad++; $display("FAIL dbz_done_width got=%0d exp=1", pulse); end
    total++; if (hi_o !== 32'h1234) begin bad++; $display("FAIL dbz_hi got=%h exp=00001234", hi_o); end
    total++; if (lo_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL dbz_lo got=%h exp=ffffffff", lo_o); end
    total++; if ({busy_o, div_by_zero_o} !== 2'b00) begin bad++; $display("FAIL dbz_after got=%b exp=00", {busy_o, div_by_zero_o}); end
  endtask

  task automatic test_busy_ignore();
    int lat; int extra;
    @(negedge clk);
    start_i = 1'b1; alu_control_i = OP_MULTU; src_a_i = 32'd6; src_b_i = 32'h00010000;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    start_i = 1'b1; alu_control_i = OP_DIVU; src_a_i = 32'd100; src_b_i = 32'd3;
    hi_we_i = 1'b1; wdata_i = 32'hAAAA;
    @(negedge clk);
    start_i = 1'b0; hi_we_i = 1'b0;
    total++; if (hi_o !== 32'h1234) begin bad++; $display("FAIL busy_hi_hold got=%h exp=00001234", hi_o); end
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      if (done_o) begin lat = 1; break; end
      @(negedge clk);
    end
    total++; if (lat !== 1) begin bad++; $display("FAIL busy_done_seen got=%0d exp=1", lat); end
    total++; if (lo_o !== 32'h00060000) begin bad++; $display("FAIL busy_first_lo got=%h exp=00060000", lo_o); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL busy_first_hi got=%h exp=00000000", hi_o); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_o || busy_o) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_no_queue got=%0d exp=0", extra); end
  endtask

  task automatic test_mthi_mtlo();
    int lat;
    @(negedge clk);
    lo_we_i = 1'b1; wdata_i = 32'h55;
    @(negedge clk);
    lo_we_i = 1'b0;
    total++; if (lo_o !== 32'h55) begin bad++; $display("FAIL mtlo got=%h exp=00000055", lo_o); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL mtlo_hi_keep got=%h exp=00000000", hi_o); end
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h1357;
    @(negedge clk);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    total++; if ({hi_o, lo_o} !== {32'h1357, 32'h1357}) begin bad++; $display("FAIL mthi_mtlo_both got=%h_%h exp=00001357_00001357", hi_o, lo_o); end
    start_i = 1'b1; alu_control_i = OP_MULTU; src_a_i = 32'd2; src_b_i = 32'd3;
    hi_we_i = 1'b1; wdata_i = 32'h77;
    @(negedge clk);
    start_i = 1'b0; hi_we_i = 1'b0;
    total++; if (hi_o !== 32'h77) begin bad++; $display("FAIL mthi_with_start got=%h exp=00000077", hi_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL start_with_mthi_busy got=%b exp=1", busy_o); end
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      if (done_o) begin lat = 1; break; end
      @(negedge clk);
    end
    total++; if ({lat[0], hi_o, lo_o} !== {1'b1, 32'h0, 32'h6}) begin bad++; $display("FAIL fix_overwrites got=%b_%h_%h exp=1_00000000_00000006", lat[0], hi_o, lo_o); end
  endtask

  task automatic test_reset_mid();
    int lat, pulse, seen; logic busy1, dbz;
    @(negedge clk);
    start_i = 1'b1; alu_control_i = OP_DIV; src_a_i = 32'd100; src_b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy_o); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy_o, done_o} !== 2'b00) begin bad++; $display("FAIL mid_reset_flags got=%b exp=00", {busy_o, done_o}); end
    total++; if ({hi_o, lo_o} !== 64'h0) begin bad++; $display("FAIL mid_reset_hilo got=%h_%h exp=0", hi_o, lo_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", seen); end
    do_op(OP_MULTU, 32'd2, 32'd3, lat, pulse, busy1, dbz);
    total++; if ({hi_o, lo_o} !== {32'h0, 32'h6}) begin bad++; $display("FAIL post_reset_mul got=%h_%h exp=00000000_00000006", hi_o, lo_o); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_busy_ignore();
    test_mthi_mtlo();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
